// File: rtl/goa_pin_bridge.sv
// Byte-wide pad interface <-> NUM_CH word-wide valid/ready core channels.
// Word to core 1 cycle after the last host byte; first outbound byte 1 cycle after arbitration.
module goa_pin_bridge #(
    parameter int WORD_W = 32,
    parameter int NUM_CH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [7:0]               ui_in,
    input  logic [7:0]               uio_in,
    output logic [7:0]               uo_out,
    output logic [7:0]               uio_out,
    output logic [7:0]               uio_oe,
    output logic [WORD_W-1:0]        core_in_data,
    output logic [NUM_CH-1:0]        core_in_valid,
    input  logic [NUM_CH-1:0]        core_in_ready,
    input  logic [NUM_CH*WORD_W-1:0] core_out_data,
    input  logic [NUM_CH-1:0]        core_out_valid,
    output logic [NUM_CH-1:0]        core_out_ready
);
    localparam int BYTES = WORD_W / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

    typedef enum logic {IN_COLLECT, IN_DELIVER} in_state_e;
    typedef enum logic {OUT_IDLE, OUT_SEND} out_state_e;

    in_state_e          in_state_q, in_state_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CH_W-1:0]    in_ch_q, in_ch_d;
    logic [WORD_W-1:0]  in_word_q, in_word_d;
    logic               err_q, err_d;
    out_state_e         out_state_q, out_state_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [WORD_W-1:0]  out_word_q, out_word_d;
    logic [CH_W-1:0]    rr_q, rr_d;
    logic               run_q, run_d;

    logic               host_valid, host_ready;
    logic [1:0]         sel;
    logic               sel_ok;
    logic               bridge_ready, bridge_valid;
    logic               pick_vld, arb_go;
    logic [CH_W-1:0]    pick_idx;
    logic               unused_bits;

    assign host_valid  = uio_in[0];
    assign host_ready  = uio_in[1];
    assign sel         = uio_in[3:2];
    assign sel_ok      = ({1'b0, sel} < 3'(NUM_CH));
    assign unused_bits = ^uio_in[7:4];

    // run_q keeps every handshake output quiet until the first edge after reset
    assign run_d        = 1'b1;
    assign bridge_ready = run_q & ena & (in_state_q == IN_COLLECT);
    assign bridge_valid = (out_state_q == OUT_SEND);

    assign uio_oe       = 8'hF0;
    assign uio_out      = {err_q, 1'b0, bridge_valid, bridge_ready, 4'b0000};
    assign uo_out       = bridge_valid ? out_word_q[{out_cnt_q, 3'b000} +: 8] : 8'h00;
    assign core_in_data = in_word_q;

    always_comb begin
        in_state_d = in_state_q;
        in_cnt_d   = in_cnt_q;
        in_ch_d    = in_ch_q;
        in_word_d  = in_word_q;
        err_d      = err_q;
        case (in_state_q)
            IN_COLLECT: begin
                if (host_valid && bridge_ready) begin
                    if (in_cnt_q == '0 && !sel_ok) begin
                        err_d = 1'b1;
                    end else begin
                        if (in_cnt_q == '0) in_ch_d = CH_W'(sel);
                        in_word_d[{in_cnt_q, 3'b000} +: 8] = ui_in;
                        if (in_cnt_q == LAST_BYTE) begin
                            in_cnt_d   = '0;
                            in_state_d = IN_DELIVER;
                        end else begin
                            in_cnt_d = in_cnt_q + 1'b1;
                        end
                    end
                end
            end
            IN_DELIVER: begin
                if (ena && core_in_ready[in_ch_q]) in_state_d = IN_COLLECT;
            end
            default: in_state_d = IN_COLLECT;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            core_in_valid[i] = (in_state_q == IN_DELIVER) && (in_ch_q == CH_W'(i));
        end
    end

    // Round-robin search starting at the pointer, wrapping modulo NUM_CH
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            if (!pick_vld && core_out_valid[(int'(rr_q) + off) % NUM_CH]) begin
                pick_vld = 1'b1;
                pick_idx = CH_W'((int'(rr_q) + off) % NUM_CH);
            end
        end
    end

    assign arb_go = run_q & ena & (out_state_q == OUT_IDLE) & pick_vld;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            core_out_ready[i] = arb_go && (pick_idx == CH_W'(i));
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        out_cnt_d   = out_cnt_q;
        out_word_d  = out_word_q;
        rr_d        = rr_q;
        case (out_state_q)
            OUT_IDLE: begin
                if (arb_go) begin
                    out_word_d  = core_out_data[int'(pick_idx)*WORD_W +: WORD_W];
                    rr_d        = CH_W'((int'(pick_idx) + 1) % NUM_CH);
                    out_cnt_d   = '0;
                    out_state_d = OUT_SEND;
                end
            end
            OUT_SEND: begin
                if (ena && host_ready) begin
                    if (out_cnt_q == LAST_BYTE) begin
                        out_cnt_d   = '0;
                        out_state_d = OUT_IDLE;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            in_state_q  <= IN_COLLECT;
            in_cnt_q    <= '0;
            in_ch_q     <= '0;
            in_word_q   <= '0;
            err_q       <= 1'b0;
            out_state_q <= OUT_IDLE;
            out_cnt_q   <= '0;
            out_word_q  <= '0;
            rr_q        <= '0;
        end else begin
            run_q       <= run_d;
            in_state_q  <= in_state_d;
            in_cnt_q    <= in_cnt_d;
            in_ch_q     <= in_ch_d;
            in_word_q   <= in_word_d;
            err_q       <= err_d;
            out_state_q <= out_state_d;
            out_cnt_q   <= out_cnt_d;
            out_word_q  <= out_word_d;
            rr_q        <= rr_d;
        end
    end
endmodule

// File: tb/tb_goa_pin_bridge.sv
// Directed bench for goa_pin_bridge with a transaction-level reference model checked every cycle.
module tb_goa_pin_bridge;
    localparam int WORD_W = 32;
    localparam int NUM_CH = 2;
    localparam int BYTES  = WORD_W / 8;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     ena = 1'b0;
    logic [7:0]               ui_in = 8'h00;
    logic                     hv = 1'b0, hr = 1'b0;
    logic [1:0]               sel = 2'd0;
    logic [7:0]               uio_in;
    logic [7:0]               uo_out, uio_out, uio_oe;
    logic [WORD_W-1:0]        core_in_data;
    logic [NUM_CH-1:0]        core_in_valid;
    logic [NUM_CH-1:0]        core_in_ready = '0;
    logic [NUM_CH*WORD_W-1:0] core_out_data = '0;
    logic [NUM_CH-1:0]        core_out_valid = '0;
    logic [NUM_CH-1:0]        core_out_ready;

    assign uio_in = {4'h0, sel, hr, hv};

    goa_pin_bridge #(.WORD_W(WORD_W), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
        .core_in_data(core_in_data), .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
        .core_out_data(core_out_data), .core_out_valid(core_out_valid), .core_out_ready(core_out_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, exp);
        end
    endtask

    // Reference model state: partial inbound word, pending delivery, outbound word in flight
    bit          m_alive, m_deliver, m_err, m_sending;
    int          m_in_cnt, m_in_ch, m_out_idx, m_rr;
    logic [31:0] m_in_word, m_out_word;

    logic [33:0] dut_in_q[$];
    logic [7:0]  dut_out_q[$];

    task automatic mdl_reset();
        m_alive = 0; m_deliver = 0; m_err = 0; m_sending = 0;
        m_in_cnt = 0; m_in_ch = 0; m_out_idx = 0; m_rr = 0;
    endtask

    task automatic step();
        bit          e_brdy;
        logic [1:0]  e_civ, e_cor;
        logic [7:0]  e_uo;
        int          pick;
        e_brdy = m_alive && ena && !m_deliver;
        e_civ  = m_deliver ? 2'(1 << m_in_ch) : 2'b00;
        e_uo   = m_sending ? 8'(m_out_word >> (8 * m_out_idx)) : 8'h00;
        pick   = -1;
        if (m_alive && ena && !m_sending) begin
            for (int off = 0; off < NUM_CH; off++) begin
                if (pick < 0 && core_out_valid[(m_rr + off) % NUM_CH]) pick = (m_rr + off) % NUM_CH;
            end
        end
        e_cor = (pick >= 0) ? 2'(1 << pick) : 2'b00;

        chk("cyc_uio_oe", 64'(uio_oe), 64'h F0);
        chk("cyc_uio_out", 64'(uio_out), 64'({m_err, 1'b0, m_sending, e_brdy, 4'b0000}));
        chk("cyc_uo_out", 64'(uo_out), 64'(e_uo));
        chk("cyc_core_in_valid", 64'(core_in_valid), 64'(e_civ));
        chk("cyc_core_out_ready", 64'(core_out_ready), 64'(e_cor));
        if (m_deliver) chk("cyc_core_in_data", 64'(core_in_data), 64'(m_in_word));

        if (rst_n) begin
            if (ena && uio_out[5] && hr) dut_out_q.push_back(uo_out);
            if (ena && |(core_in_valid & core_in_ready)) dut_in_q.push_back({core_in_valid, core_in_data});

            if (e_brdy && hv) begin
                if (m_in_cnt == 0 && int'(sel) >= NUM_CH) begin
                    m_err = 1;
                end else begin
                    if (m_in_cnt == 0) begin
                        m_in_ch   = int'(sel);
                        m_in_word = 32'h0;
                    end
                    m_in_word = m_in_word | (32'(ui_in) << (8 * m_in_cnt));
                    m_in_cnt++;
                    if (m_in_cnt == BYTES) begin
                        m_deliver = 1;
                        m_in_cnt  = 0;
                    end
                end
            end else if (m_deliver && ena && core_in_ready[m_in_ch]) begin
                m_deliver = 0;
            end

            if (m_sending && ena && hr) begin
                m_out_idx++;
                if (m_out_idx == BYTES) m_sending = 0;
            end else if (pick >= 0) begin
                m_sending  = 1;
                m_out_idx  = 0;
                m_out_word = core_out_data[pick*WORD_W +: WORD_W];
                m_rr       = (pick + 1) % NUM_CH;
            end
            m_alive = 1;
        end
    endtask

    initial begin
        mdl_reset();
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) mdl_reset();
            step();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge; returns at the negedge following acceptance
    task automatic send_byte(input logic [7:0] b, input logic [1:0] s);
        ui_in = b; sel = s; hv = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #3;
            if (uio_out[4]) begin
                @(negedge clk);
                hv = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("send_timeout", 64'd1, 64'd0);
        hv = 1'b0;
    endtask

    task automatic wait_pick(output logic [1:0] r);
        r = 2'b00;
        for (int i = 0; i < 50; i++) begin
            #3;
            if (core_out_ready != 0) begin
                r = core_out_ready;
                @(negedge clk);
                core_out_valid = core_out_valid & ~r;
                return;
            end
            @(negedge clk);
        end
        chk("pick_timeout", 64'd1, 64'd0);
    endtask

    logic [1:0]  r;
    logic [7:0]  exp4[8]   = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01};
    logic [7:0]  exp5[4]   = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    bit          t_ena[9]  = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    bit          t_hr[9]   = '{1, 0, 0, 1, 1, 1, 1, 1, 0};
    bit          t_hv[9]   = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [7:0]  t_ui[9]   = '{8'hA0, 8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'hA2, 8'hA3, 8'h00, 8'h00};

    initial begin
        ena = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #3 chk("rst_uio_out", 64'(uio_out), 64'h00);
        chk("rst_uio_oe", 64'(uio_oe), 64'hF0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        // 1: idle after reset
        #3 chk("t1_uio_oe", 64'(uio_oe), 64'hF0);
        chk("t1_uio_out", 64'(uio_out), 64'h10);
        chk("t1_uo_out", 64'(uo_out), 64'h00);
        chk("t1_civ", 64'(core_in_valid), 64'h0);
        @(negedge clk);

        // 2: channel latched at byte 0, later select changes ignored
        send_byte(8'h11, 2'd1);
        send_byte(8'h22, 2'd0);
        send_byte(8'h33, 2'd0);
        send_byte(8'h44, 2'd0);
        #3 chk("t2_civ", 64'(core_in_valid), 64'h2);
        chk("t2_data", 64'(core_in_data), 64'h44332211);
        chk("t2_brdy_low", 64'(uio_out[4]), 64'h0);
        repeat (2) @(negedge clk);
        #3 chk("t2_brdy_hold", 64'(uio_out[4]), 64'h0);
        @(negedge clk);
        core_in_ready = 2'b10;
        @(negedge clk);
        core_in_ready = 2'b00;
        #3 chk("t2_brdy_back", 64'(uio_out[4]), 64'h1);
        chk("t2_n_words", 64'(dut_in_q.size()), 64'd1);
        if (dut_in_q.size() > 0) chk("t2_word", 64'(dut_in_q.pop_front()), 64'({2'b10, 32'h44332211}));
        @(negedge clk);

        // 3: bad select sets sticky error, following word unaffected
        send_byte(8'hAA, 2'd3);
        #3 chk("t3_err", 64'(uio_out[7]), 64'h1);
        chk("t3_civ", 64'(core_in_valid), 64'h0);
        @(negedge clk);
        core_in_ready = 2'b01;
        send_byte(8'h01, 2'd0);
        send_byte(8'h02, 2'd1);
        send_byte(8'h03, 2'd0);
        send_byte(8'h04, 2'd0);
        repeat (2) @(negedge clk);
        #3 chk("t3_n_words", 64'(dut_in_q.size()), 64'd1);
        if (dut_in_q.size() > 0) chk("t3_word", 64'(dut_in_q.pop_front()), 64'({2'b01, 32'h04030201}));
        chk("t3_err_sticky", 64'(uio_out[7]), 64'h1);
        @(negedge clk);

        // 4: both channels valid, round-robin order and LSB-first serialisation
        core_out_data  = {32'h01234567, 32'hDEADBEEF};
        hr             = 1'b1;
        core_out_valid = 2'b11;
        wait_pick(r);
        chk("t4_pick0", 64'(r), 64'h1);
        wait_pick(r);
        chk("t4_pick1", 64'(r), 64'h2);
        for (int i = 0; i < 50 && dut_out_q.size() < 8; i++) @(negedge clk);
        chk("t4_n_bytes", 64'(dut_out_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (dut_out_q.size() > 0) chk("t4_byte", 64'(dut_out_q.pop_front()), 64'(exp4[i]));
        end
        hr = 1'b0;
        dut_out_q.delete();
        @(negedge clk);

        // 5: host stalls and enable drop during simultaneous in/out words
        core_out_data[31:0] = 32'hCAFEF00D;
        core_out_valid      = 2'b01;
        wait_pick(r);
        chk("t5_pick", 64'(r), 64'h1);
        for (int c = 0; c < 9; c++) begin
            ena = t_ena[c]; hr = t_hr[c]; hv = t_hv[c]; ui_in = t_ui[c]; sel = 2'd0;
            @(negedge clk);
        end
        ena = 1'b1; hr = 1'b0; hv = 1'b0;
        repeat (2) @(negedge clk);
        #3 chk("t5_n_bytes", 64'(dut_out_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (dut_out_q.size() > 0) chk("t5_byte", 64'(dut_out_q.pop_front()), 64'(exp5[i]));
        end
        chk("t5_n_words", 64'(dut_in_q.size()), 64'd1);
        if (dut_in_q.size() > 0) chk("t5_word", 64'(dut_in_q.pop_front()), 64'({2'b01, 32'hA3A2A1A0}));
        @(negedge clk);

        // 6: reset mid inbound and mid outbound word
        core_out_data[63:32] = 32'h89ABCDEF;
        core_out_valid       = 2'b10;
        hr                   = 1'b1;
        wait_pick(r);
        chk("t6_pick", 64'(r), 64'h2);
        send_byte(8'h91, 2'd0);
        hr = 1'b0;
        send_byte(8'h92, 2'd0);
        core_out_valid = 2'b01;
        rst_n          = 1'b0;
        #1 chk("t6_uo_out", 64'(uo_out), 64'h00);
        chk("t6_uio_out", 64'(uio_out), 64'h00);
        chk("t6_uio_oe", 64'(uio_oe), 64'hF0);
        chk("t6_civ", 64'(core_in_valid), 64'h0);
        chk("t6_cor", 64'(core_out_ready), 64'h0);
        repeat (2) @(negedge clk);
        core_out_valid = 2'b00;
        rst_n          = 1'b1;
        @(negedge clk);
        send_byte(8'h55, 2'd0);
        send_byte(8'h66, 2'd0);
        send_byte(8'h77, 2'd0);
        send_byte(8'h88, 2'd0);
        repeat (2) @(negedge clk);
        #3 chk("t6_n_words", 64'(dut_in_q.size()), 64'd1);
        if (dut_in_q.size() > 0) chk("t6_word", 64'(dut_in_q.pop_front()), 64'({2'b01, 32'h88776655}));
        chk("t6_n_bytes", 64'(dut_out_q.size()), 64'd1);
        if (dut_out_q.size() > 0) chk("t6_byte", 64'(dut_out_q.pop_front()), 64'hEF);
        chk("t6_err_cleared", 64'(uio_out[7]), 64'h0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/goa_pin_bridge.md
Name: goa_pin_bridge

Overview:
Parametrised pin-level bridge between the byte-wide Tiny Tapeout pad interface (ui_in/uo_out/uio) and NUM_CH word-wide valid/ready channels inside the GOA core. Inbound, it assembles WORD_W/8 host bytes into one word and delivers it to a selected channel. Outbound, it round-robin arbitrates among core channels and serialises one word at a time back to the host. It generalises the fixed 8-bit flat pin mapping into a multi-channel, multi-byte, handshaked transport.

Parameters:
WORD_W, 32, internal word width; multiple of 8, range 8..64; BYTES = WORD_W/8
NUM_CH, 2, number of core channels; range 1..4

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; low freezes both FSMs
ui_in  in  8  host inbound byte
uio_in  in  8  [0] host_valid, [1] host_ready, [3:2] channel select, [7:4] unused
uo_out  out  8  outbound byte
uio_out  out  8  [4] bridge_ready, [5] bridge_valid, [7] sticky channel error, [6] and [3:0] constant 0
uio_oe  out  8  constant 8'hF0
core_in_data  out  WORD_W  assembled inbound word, shared by all channels
core_in_valid  out  NUM_CH  one-hot inbound word valid
core_in_ready  in  NUM_CH  per-channel inbound ready
core_out_data  in  NUM_CH*WORD_W  per-channel outbound words; channel i at [i*WORD_W +: WORD_W]
core_out_valid  in  NUM_CH  per-channel outbound valid
core_out_ready  out  NUM_CH  one-hot, single-cycle outbound accept

Behaviour:
- Reset: all outputs 0 except uio_oe = 8'hF0. Both FSMs go to their first state, the byte counters clear, the RR pointer is 0, and err is cleared. Only reset clears err.
- ena low: nothing is accepted or advanced. bridge_ready reads 0. bridge_valid, uo_out and core_in_valid hold their values.
- Inbound FSM, IN_COLLECT:
  - bridge_ready = 1.
  - A byte is accepted on a clk edge where host_valid & bridge_ready & ena.
  - Byte k of the word (k = 0..BYTES-1) goes to word bits [8k+7:8k], little-endian.
  - The channel is latched from uio_in[3:2] at byte 0. Changes to the select during bytes 1..BYTES-1 are ignored.
  - Byte 0 with select >= NUM_CH is dropped: err is set, the counter does not advance, and the FSM stays in IN_COLLECT.
  - When the last byte is accepted, the FSM moves to IN_DELIVER on the next cycle.
- Inbound FSM, IN_DELIVER:
  - bridge_ready = 0. core_in_valid[ch] = 1 and core_in_data is stable.
  - On core_in_valid[ch] & core_in_ready[ch], the FSM returns to IN_COLLECT and the counter clears. bridge_ready is 1 again on the following cycle.
  - A core ready asserted early (before valid) is harmless.
- Outbound FSM, OUT_IDLE:
  - If any core_out_valid is set, pick the first valid channel at or after the RR pointer, wrapping modulo NUM_CH.
  - In that same cycle: pulse core_out_ready[i] for one cycle, capture the word, and set the RR pointer to (i+1) mod NUM_CH.
  - Next state is OUT_SEND.
- Outbound FSM, OUT_SEND:
  - bridge_valid = 1 and uo_out = byte k of the captured word, LSB byte first.
  - The byte advances on host_ready & bridge_valid & ena.
  - After byte BYTES-1 is taken, bridge_valid drops on the next cycle and the FSM returns to OUT_IDLE.
  - The earliest next arbitration is the cycle after that, so the minimum gap between words is one cycle.
- Latency:
  - Inbound: word visible on core_in_valid 1 cycle after the last byte edge.
  - Outbound: first byte visible 1 cycle after the arbitration edge.
- The inbound and outbound FSMs are fully independent and operate simultaneously.
- Reset asserted mid-word discards the partial word and any in-flight outbound word immediately (asynchronously). No core handshake is issued.
- With WORD_W = 8: BYTES = 1, IN_COLLECT lasts a single accepted byte, and the counters are degenerate but legal.

Test Plan:
1. Reset, then idle -> uio_oe = 8'hF0, bridge_ready = 1, bridge_valid = 0, uo_out = 0, err = 0, core_in_valid = 0.
2. Select = 1. Send bytes 0x11, 0x22, 0x33, 0x44 with host_valid; the select changes to 0 after byte 0 -> core_in_valid = 2'b10 and core_in_data = 32'h44332211 one cycle after the last byte. bridge_ready stays 0 until core_in_ready[1] is given, then returns to 1.
3. Select = 3 with NUM_CH = 2, send byte 0xAA -> err (uio_out[7]) = 1 and stays set. The next valid 4-byte word on channel 0 still delivers correctly, and err remains 1 until reset.
4. core_out_valid = 2'b11 with words 32'hDEADBEEF (ch0) and 32'h01234567 (ch1), host_ready = 1 -> one-cycle pulse on core_out_ready[0]. uo_out shows EF, BE, AD, DE. Then core_out_ready[1] pulses and uo_out shows 67, 45, 23, 01.
5. Outbound word with host_ready toggling 1,0,0,1; also drop ena for 3 cycles mid-inbound-word -> outbound bytes are held while stalled with none skipped or duplicated, the inbound counter freezes, and the word assembles correctly after ena returns.
6. Assert rst_n low after 2 of 4 inbound bytes and mid-outbound-word -> all outputs go to their reset values immediately. The first 4 bytes sent after reset form a complete new word, and no core handshake fires for the aborted words.
